// File: rtl/crack_sched_pkg.sv
// crack_sched_pkg: shared state encodings and limits for the key-space search scheduler
package crack_sched_pkg;
    localparam int MAX_CH = 8;
    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} top_state_t;
    typedef enum logic [1:0] {CH_IDLE, CH_ISSUED, CH_RUN} ch_state_t;
endpackage

// File: rtl/crack_sched_ch.sv
// crack_sched_ch: one worker channel; tracks the worker's progress and holds its key until return
module crack_sched_ch
    import crack_sched_pkg::*;
#(
    parameter int KEY_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic [KEY_W-1:0] issue_key,
    input  logic             wk_rdy,
    input  logic             wk_hit,
    output logic             idle,
    output logic             ret,
    output logic             ret_hit,
    output logic [KEY_W-1:0] wk_key
);
    ch_state_t state, state_nxt;
    logic [KEY_W-1:0] key_q;

    assign idle    = state == CH_IDLE;
    assign ret     = state == CH_RUN && wk_rdy;
    assign ret_hit = ret && wk_hit;
    assign wk_key  = issue ? issue_key : key_q;

    // channel state and the key the worker is chewing on
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CH_IDLE;
            key_q <= '0;
        end else begin
            state <= state_nxt;
            if (issue) key_q <= issue_key;
        end
    end

    // the issued cycle skips wk_rdy since the worker may not have dropped it yet
    always_comb begin
        state_nxt = state == CH_IDLE   ? (issue ? CH_ISSUED : CH_IDLE) :
                    state == CH_ISSUED ? CH_RUN :
                    (ret ? CH_IDLE : CH_RUN);
    end
endmodule

// File: rtl/crack_sched.sv
// crack_sched: farms a key range out to NUM_CH workers and reports the first hit; CRACK_SCHED_PERF_EN adds keys_tried
module crack_sched
    import crack_sched_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int KEY_W  = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    output logic                    rdy,
    input  logic [KEY_W-1:0]        key_lo,
    input  logic [KEY_W-1:0]        key_hi,
    output logic [KEY_W-1:0]        key,
    output logic                    key_valid,
    output logic [NUM_CH-1:0]       wk_en,
    input  logic [NUM_CH-1:0]       wk_rdy,
    output logic [NUM_CH*KEY_W-1:0] wk_key,
    input  logic [NUM_CH-1:0]       wk_hit
`ifdef CRACK_SCHED_PERF_EN
    ,
    output logic [KEY_W:0]          keys_tried
`endif
);
    top_state_t state, state_nxt;
    logic [KEY_W:0] next_key;
    logic [KEY_W-1:0] hi, hit_key;
    logic [NUM_CH-1:0] idle, ret, ret_hit, cand;
    logic start, more, can_issue, done;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            crack_sched_ch #(.KEY_W(KEY_W)) u_ch (
                .clk(clk),
                .rst(rst),
                .issue(wk_en[i]),
                .issue_key(next_key[KEY_W-1:0]),
                .wk_rdy(wk_rdy[i]),
                .wk_hit(wk_hit[i]),
                .idle(idle[i]),
                .ret(ret[i]),
                .ret_hit(ret_hit[i]),
                .wk_key(wk_key[i*KEY_W +: KEY_W])
            );
        end
    endgenerate

    // next_key carries an extra bit so a range ending at all-ones still runs out
    assign rdy       = state == IDLE;
    assign start     = rdy && en;
    assign more      = next_key <= {1'b0, hi};
    assign can_issue = state == DISPATCH && more && !key_valid && !rst;
    assign cand      = idle & wk_rdy & {NUM_CH{can_issue}};
    assign wk_en     = cand & -cand;
    assign done      = &(idle | ret);

    // top sequencing: accept, dispatch until exhausted or hit, then wait for every worker
    always_comb begin
        state_nxt = state == IDLE     ? (en ? DISPATCH : IDLE) :
                    state == DISPATCH ? ((key_valid || !more) ? DRAIN : DISPATCH) :
                    (done ? IDLE : DRAIN);
    end

    // lowest-index channel wins among simultaneous hits
    always_comb begin
        hit_key = '0;
        for (int c = NUM_CH - 1; c >= 0; c--)
            if (ret_hit[c]) hit_key = wk_key[c*KEY_W +: KEY_W];
    end

    // search registers; only the first recorded hit sticks
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            next_key  <= '0;
            hi        <= '0;
            key       <= '0;
            key_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                next_key  <= {1'b0, key_lo};
                hi        <= key_hi;
                key_valid <= 1'b0;
            end else begin
                if (|wk_en) next_key <= next_key + (KEY_W+1)'(1);
                if (|ret_hit && !key_valid) begin
                    key       <= hit_key;
                    key_valid <= 1'b1;
                end
            end
        end
    end

`ifdef CRACK_SCHED_PERF_EN
    // count worker returns for the current search
    always_ff @(posedge clk) begin
        if (rst || start) keys_tried <= '0;
        else keys_tried <= keys_tried + (KEY_W+1)'($countones(ret));
    end
`endif
endmodule
